// File: rtl/scm_write_arbiter_if.sv
// Request bus between the write requesters and scm_write_arbiter.
// master: requester side, slave: arbiter side.
interface scm_write_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8
);
  logic [N_PORTS-1:0]                    req_valid_i;
  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]    req_addr_i;
  logic [N_PORTS-1:0][NUM_BYTE-1:0][7:0] req_wdata_i;
  logic [N_PORTS-1:0][NUM_BYTE-1:0]      req_be_i;
  logic [N_PORTS-1:0]                    req_ready_o;

  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, req_be_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, req_be_i,
    output req_ready_o
  );
endinterface

// File: rtl/scm_write_arbiter.sv
// Round-robin write arbiter in front of a single-write-port latch register
// file. One grant per cycle, registered write port, two-stage in-flight
// address tracking for reader hazard checks.
// Optional feature macro: SCM_WRITE_MERGE_EN -- same-address requests with
// disjoint byte enables are merged into the round-robin winner's write.
module scm_write_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst,
  scm_write_arbiter_if.slave             req,
  output logic                           WriteEnable,
  output logic [ADDR_WIDTH-1:0]          WriteAddr,
  output logic [NUM_BYTE-1:0][7:0]       WriteData,
  output logic [NUM_BYTE-1:0]            WriteBE,
  output logic [1:0]                     pend_valid_o,
  output logic [1:0][ADDR_WIDTH-1:0]     pend_addr_o
);

  localparam int unsigned PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [PTR_W-1:0]          rr_q;
  logic                      pend1_valid_q;
  logic [ADDR_WIDTH-1:0]     pend1_addr_q;

  logic                      found_c;
  logic [PTR_W-1:0]          win_c;
  logic [PTR_W:0]            sum_c;
  logic [PTR_W-1:0]          idx_c;
  logic [N_PORTS-1:0]        grant_c;
  logic [NUM_BYTE-1:0]       be_m_c;
  logic [NUM_BYTE-1:0][7:0]  data_m_c;

  // Round-robin search from rr_q, wrapping at N_PORTS-1; first valid port wins.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    sum_c   = '0;
    idx_c   = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      sum_c = {1'b0, rr_q} + (PTR_W+1)'(i);
      if (sum_c >= (PTR_W+1)'(N_PORTS)) begin
        sum_c = sum_c - (PTR_W+1)'(N_PORTS);
      end
      idx_c = sum_c[PTR_W-1:0];
      if (!found_c && req.req_valid_i[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
  end

  // Grant vector plus merged byte enables and lane data of all granted ports.
  always_comb begin
    grant_c  = '0;
    be_m_c   = req.req_be_i[win_c];
    data_m_c = req.req_wdata_i[win_c];
    grant_c[win_c] = found_c;
`ifdef SCM_WRITE_MERGE_EN
    // Overlap is checked against the lanes already claimed, so two merged
    // non-winners can never fight over the same lane.
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (found_c && (PTR_W'(p) != win_c) && req.req_valid_i[p] &&
          (req.req_addr_i[p] == req.req_addr_i[win_c]) &&
          ((req.req_be_i[p] & be_m_c) == '0)) begin
        grant_c[p] = 1'b1;
        be_m_c     = be_m_c | req.req_be_i[p];
      end
    end
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      for (int unsigned b = 0; b < NUM_BYTE; b++) begin
        if (grant_c[p] && req.req_be_i[p][b]) begin
          data_m_c[b] = req.req_wdata_i[p][b];
        end
      end
    end
`endif
  end

  // Ready is the grant itself, forced low throughout reset.
  assign req.req_ready_o = rst ? '0 : grant_c;

  // Stage 0 of the in-flight tracker is the issued write itself.
  assign pend_valid_o = {pend1_valid_q, WriteEnable};
  assign pend_addr_o  = {pend1_addr_q, WriteAddr};

  // Priority pointer advances past the round-robin winner only.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else if (found_c) begin
      rr_q <= (win_c == PTR_W'(N_PORTS - 1)) ? '0 : win_c + PTR_W'(1);
    end
  end

  // Issue stage: zero-BE transfers are accepted but issue no strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      WriteEnable <= 1'b0;
      WriteAddr   <= '0;
      WriteData   <= '0;
      WriteBE     <= '0;
    end else begin
      WriteEnable <= found_c && (be_m_c != '0);
      if (found_c) begin
        WriteAddr <= req.req_addr_i[win_c];
        WriteData <= data_m_c;
        WriteBE   <= be_m_c;
      end
    end
  end

  // Latch-update stage: stage 0 delayed by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend1_valid_q <= 1'b0;
      pend1_addr_q  <= '0;
    end else begin
      pend1_valid_q <= WriteEnable;
      pend1_addr_q  <= WriteAddr;
    end
  end

endmodule

// File: tb/tb_scm_write_arbiter.sv
// Directed bench for scm_write_arbiter (2 ports, 5-bit address, 32-bit data).
module tb_scm_write_arbiter;

  logic clk;
  logic rst;
  logic             WriteEnable;
  logic [4:0]       WriteAddr;
  logic [3:0][7:0]  WriteData;
  logic [3:0]       WriteBE;
  logic [1:0]       pend_valid_o;
  logic [1:0][4:0]  pend_addr_o;

  int n_cmp;
  int n_err;

  scm_write_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .N_PORTS(2)) bus ();

  scm_write_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .N_PORTS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (bus),
    .WriteEnable  (WriteEnable),
    .WriteAddr    (WriteAddr),
    .WriteData    (WriteData),
    .WriteBE      (WriteBE),
    .pend_valid_o (pend_valid_o),
    .pend_addr_o  (pend_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    bus.req_valid_i[p] = v;
    bus.req_addr_i[p]  = a;
    bus.req_wdata_i[p] = d;
    bus.req_be_i[p]    = be;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    drive(0, 1'b1, 5'd1, 32'h11111111, 4'hF);
    drive(1, 1'b1, 5'd2, 32'h22222222, 4'hF);

    // Reset held 3 cycles with all ports valid
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_ready", 64'(bus.req_ready_o), 64'h0);
      check("rst_we", 64'(WriteEnable), 64'h0);
      check("rst_pend", 64'(pend_valid_o), 64'h0);
    end
    check("rst_addr", 64'(WriteAddr), 64'h0);
    rst = 1'b0;
    #1;
    check("first_grant", 64'(bus.req_ready_o), 64'h1);

    // Round robin, addresses 3 and 7
    drive(0, 1'b1, 5'd3, 32'h33333333, 4'hF);
    drive(1, 1'b1, 5'd7, 32'h77777777, 4'hF);
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rr_ready", 64'(bus.req_ready_o), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      check("rr_we", 64'(WriteEnable), 64'h1);
      check("rr_addr", 64'(WriteAddr), (k % 2 == 0) ? 64'd3 : 64'd7);
    end

    // Idle: strobe drops, write port holds
    drive(0, 1'b0, 5'd0, 32'h0, 4'h0);
    drive(1, 1'b0, 5'd0, 32'h0, 4'h0);
    #1;
    check("idle_ready", 64'(bus.req_ready_o), 64'h0);
    tick();
    check("idle_we", 64'(WriteEnable), 64'h0);
    check("idle_hold_addr", 64'(WriteAddr), 64'd7);
    check("idle_hold_data", 64'(WriteData), 64'h77777777);

    // Zero byte enables: accepted, no strobe, pointer back to 0
    drive(1, 1'b1, 5'd5, 32'h55555555, 4'h0);
    #1;
    check("zbe_ready", 64'(bus.req_ready_o), 64'h2);
    tick();
    drive(1, 1'b0, 5'd0, 32'h0, 4'h0);
    check("zbe_we", 64'(WriteEnable), 64'h0);
    check("zbe_addr", 64'(WriteAddr), 64'd5);
    check("zbe_be", 64'(WriteBE), 64'h0);
    drive(0, 1'b1, 5'd1, 32'h11111111, 4'hF);
    drive(1, 1'b1, 5'd2, 32'h22222222, 4'hF);
    #1;
    check("zbe_rr", 64'(bus.req_ready_o), 64'h1);
    tick();
    drive(0, 1'b0, 5'd0, 32'h0, 4'h0);
    drive(1, 1'b0, 5'd0, 32'h0, 4'h0);
    tick();
    tick();

    // Pending stages for a single write to address 9
    drive(0, 1'b1, 5'd9, 32'h99999999, 4'hF);
    tick();
    drive(0, 1'b0, 5'd0, 32'h0, 4'h0);
    check("pend_t1_valid", 64'(pend_valid_o), 64'h1);
    check("pend_t1_addr", 64'(pend_addr_o[0]), 64'd9);
    tick();
    check("pend_t2_valid", 64'(pend_valid_o), 64'h2);
    check("pend_t2_addr", 64'(pend_addr_o[1]), 64'd9);
    tick();
    check("pend_t3_valid", 64'(pend_valid_o), 64'h0);

    // Same address, disjoint byte enables (pointer is at port 1)
    drive(0, 1'b1, 5'd4, 32'h0000BEEF, 4'b0011);
    drive(1, 1'b1, 5'd4, 32'hCAFE0000, 4'b1100);
    #1;
`ifdef SCM_WRITE_MERGE_EN
    check("merge_ready", 64'(bus.req_ready_o), 64'h3);
    tick();
    drive(0, 1'b0, 5'd0, 32'h0, 4'h0);
    drive(1, 1'b0, 5'd0, 32'h0, 4'h0);
    check("merge_we", 64'(WriteEnable), 64'h1);
    check("merge_addr", 64'(WriteAddr), 64'd4);
    check("merge_be", 64'(WriteBE), 64'hF);
    check("merge_data", 64'(WriteData), 64'hCAFEBEEF);
`else
    check("ser1_ready", 64'(bus.req_ready_o), 64'h2);
    tick();
    drive(1, 1'b0, 5'd0, 32'h0, 4'h0);
    check("ser1_we", 64'(WriteEnable), 64'h1);
    check("ser1_be", 64'(WriteBE), 64'hC);
    check("ser1_data", 64'(WriteData), 64'hCAFE0000);
    #1;
    check("ser2_ready", 64'(bus.req_ready_o), 64'h1);
    tick();
    drive(0, 1'b0, 5'd0, 32'h0, 4'h0);
    check("ser2_we", 64'(WriteEnable), 64'h1);
    check("ser2_addr", 64'(WriteAddr), 64'd4);
    check("ser2_be", 64'(WriteBE), 64'h3);
    check("ser2_data", 64'(WriteData), 64'h0000BEEF);
`endif

    // Reset one cycle after a grant discards the in-flight write
    drive(1, 1'b1, 5'd12, 32'hC0C0C0C0, 4'hF);
    #1;
    check("mrst_grant", 64'(bus.req_ready_o), 64'h2);
    tick();
    drive(1, 1'b0, 5'd0, 32'h0, 4'h0);
    drive(0, 1'b1, 5'd1, 32'h11111111, 4'hF);
    rst = 1'b1;
    #1;
    check("mrst_ready", 64'(bus.req_ready_o), 64'h0);
    check("mrst_we_t1", 64'(WriteEnable), 64'h1);
    tick();
    check("mrst_we_t2", 64'(WriteEnable), 64'h0);
    check("mrst_pend", 64'(pend_valid_o), 64'h0);
    check("mrst_addr", 64'(WriteAddr), 64'h0);
    rst = 1'b0;

    // Losing port changes address/data while waiting; grant-cycle values used
    drive(0, 1'b1, 5'd10, 32'hAAAAAAAA, 4'hF);
    drive(1, 1'b1, 5'd11, 32'hBBBBBBBB, 4'hF);
    #1;
    check("mrst_rr", 64'(bus.req_ready_o), 64'h1);
    tick();
    check("chg_addr0", 64'(WriteAddr), 64'd10);
    drive(0, 1'b0, 5'd0, 32'h0, 4'h0);
    drive(1, 1'b1, 5'd13, 32'h13131313, 4'hF);
    #1;
    check("chg_ready", 64'(bus.req_ready_o), 64'h2);
    tick();
    drive(1, 1'b0, 5'd0, 32'h0, 4'h0);
    check("chg_addr1", 64'(WriteAddr), 64'd13);
    check("chg_data1", 64'(WriteData), 64'h13131313);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
